crc_frame_serializer: RTL
=========================

Name: crc_frame_serializer

Overview:
- Upstream feeder for the serial CRC generator.
- Accepts parallel payload bytes from a valid/ready source and buffers whole frames in a small FIFO.
- Shifts each frame LSB-first into the generator's data/active inputs as one contiguous active burst.
- Then holds active low long enough for the generator to emit its CRC_WIDTH-bit checksum before starting the next frame.

Parameters:
DATA_WIDTH, 8, payload word width in bits
CRC_WIDTH, 8, checksum length; sets the post-frame gap
FIFO_DEPTH, 4, byte entries (power of 2, >=2); also the maximum frame length in words

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_data  input  DATA_WIDTH  payload word
in_valid  input  1  in_data valid
in_last  input  1  word is last of frame
in_ready  output  1  FIFO can accept a word this cycle
ser_data  output  1  serial bit to CRC data input
ser_active  output  1  to CRC active input; high for exactly 8*N contiguous cycles per N-word frame
busy  output  1  state != IDLE
frame_done  output  1  one-cycle pulse at end of CRC gap
frame_err  output  1  one-cycle pulse on overflow flush

Behaviour:
- Reset (async, rst=1): FIFO empty, frames_pending=0, state IDLE. All outputs 0 except in_ready; in_ready=1 after release.
- Write side:
  - A word is accepted when in_valid && in_ready.
  - Stores {in_last, in_data}; frames_pending increments on an accepted word with in_last=1.
  - in_ready = !full && state != FLUSH.
- Read side: a pop in the same cycle as a push is legal, and count stays constant.
- FSM states: IDLE, SHIFT, GAP, FLUSH.
- IDLE:
  - If frames_pending>0, pop the head word into the shift register, bit_cnt=0, go to SHIFT.
  - ser_active rises on the next edge with ser_data=word[0].
  - Otherwise, if full && frames_pending==0, go to FLUSH.
- SHIFT:
  - Each cycle ser_data=shreg[0] and ser_active=1; shift right.
  - After DATA_WIDTH bits: if the current word was not last, pop the next word with no bubble. A complete frame is guaranteed present.
  - If it was last: decrement frames_pending, go to GAP, gap_cnt=0.
  - ser_data and ser_active are registered, so bit k of word j appears exactly j*DATA_WIDTH+k cycles after the first bit.
- GAP:
  - ser_active=0, ser_data=0 for CRC_WIDTH+1 cycles. The extra cycle covers the generator's registered valid.
  - On the last gap cycle, frame_done=1 and the FSM returns to IDLE.
  - A back-to-back pending frame starts its first bit on the cycle after IDLE is entered.
- FLUSH:
  - One cycle: FIFO cleared, frame_err=1, in_ready=0, then back to IDLE.
  - Triggered only by a frame longer than FIFO_DEPTH words.
- Simultaneous events:
  - An in_last push in the same cycle IDLE evaluates frames_pending is not seen until the next cycle.
  - A frames_pending decrement and increment in the same cycle net to zero.
- Counter widths:
  - bit_cnt is clog2(DATA_WIDTH).
  - gap_cnt is clog2(CRC_WIDTH+2).
  - FIFO pointers are clog2(FIFO_DEPTH) and wrap modulo FIFO_DEPTH.
  - count is clog2(FIFO_DEPTH)+1.
- Reset mid-SHIFT or mid-GAP:
  - ser_active drops immediately; FIFO and pending frames are discarded.
  - No frame_done pulse is generated.

Test Plan:
1. Single word 0xA5 with last -> ser_active high 8 cycles, ser_data 1,0,1,0,0,1,0,1; then 9 low cycles; frame_done pulses once; CRC generator emits checksum matching the software model.
2. Two-word frame 0x12,0x34 pushed back-to-back -> 16 contiguous active cycles, bits 0x12 LSB-first then 0x34 LSB-first, no bubble between words.
3. Two one-word frames queued while busy -> second frame's first bit appears 1 cycle after the first frame_done pulse; in_ready stays 1 throughout.
4. Five words with no in_last (FIFO_DEPTH=4):
   - after 4th accept, in_ready=0 and one frame_err pulse;
   - FIFO is empty and ser_active never rises;
   - a following 0xFF with last serializes normally.
5. rst=1 asserted on 5th bit of SHIFT -> ser_active=0 and busy=0 in the same cycle (asynchronous); after release, FIFO is empty and no frame_done occurs.
6. Push of a last word coincident with the pop of the final bit of the previous frame -> frames_pending stays correct, and both frames serialize with the exact 9-cycle gap.

Source files
------------

// File: rtl/crc_frame_serializer.sv
// Buffers whole payload frames in a small FIFO and shifts each one LSB-first into a
// serial CRC generator, then idles long enough for the checksum to come out.
module crc_frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CRC_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  ser_data,
  output logic                  ser_active,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int GW = $clog2(CRC_WIDTH + 2);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(CRC_WIDTH - 1);

  // Handshake: a word transfers on a rising clk edge where in_valid && in_ready;
  // in_ready never depends on in_valid, and in_data/in_last are held while in_valid waits.

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, FLUSH} state_t;
  state_t state;

  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         pending;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic                  cur_last;

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  pop_idle;
  logic                  word_end;
  logic                  pend_inc;
  logic                  pend_dec;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;

  assign full      = (count == DEPTH_C);
  assign in_ready  = !full && (state != FLUSH);
  assign push      = in_valid && in_ready;
  assign head_data = mem[rd_ptr][DATA_WIDTH-1:0];
  assign head_last = mem[rd_ptr][DATA_WIDTH];
  assign pop_idle  = (state == IDLE) && (pending != '0);
  assign word_end  = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign pop       = pop_idle || (word_end && !cur_last);
  assign pend_inc  = push && in_last;
  assign pend_dec  = word_end && cur_last;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (state == FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Complete frames held in the FIFO; a frame leaving and one arriving cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (pend_inc && !pend_dec) begin
      pending <= pending + 1'b1;
    end else if (pend_dec && !pend_inc) begin
      pending <= pending - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      cur_last   <= 1'b0;
      ser_data   <= 1'b0;
      ser_active <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_idle) begin
            shreg      <= head_data >> 1;
            ser_data   <= head_data[0];
            ser_active <= 1'b1;
            cur_last   <= head_last;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end else if (full) begin
            // Full with no terminated frame: the frame can never fit, drop it.
            frame_err <= 1'b1;
            state     <= FLUSH;
          end
        end
        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            if (!cur_last) begin
              shreg    <= head_data >> 1;
              ser_data <= head_data[0];
              cur_last <= head_last;
              bit_cnt  <= '0;
            end else begin
              ser_data   <= 1'b0;
              ser_active <= 1'b0;
              gap_cnt    <= '0;
              state      <= GAP;
            end
          end else begin
            ser_data <= shreg[0];
            shreg    <= shreg >> 1;
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        GAP: begin
          // The cycle spent in IDLE after this completes the CRC_WIDTH+1 quiet cycles.
          if (gap_cnt == GAP_END) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        FLUSH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
